// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard-control bundle: stage icodes/registers/status in, stall/bubble controls and counters out.
interface pipe_hazard_ctrl_if;
    logic [3:0]  D_icode_i;
    logic [3:0]  E_icode_i;
    logic [3:0]  M_icode_i;
    logic [3:0]  E_dstM_i;
    logic [3:0]  d_srcA_i;
    logic [3:0]  d_srcB_i;
    logic        e_Cnd_i;
    logic [2:0]  m_stat_i;
    logic [2:0]  W_stat_i;

    logic        F_stall_o;
    logic        D_stall_o;
    logic        D_bubble_o;
    logic        E_bubble_o;
    logic        M_bubble_o;
    logic        W_stall_o;
    logic        cpu_halt_o;
    logic [2:0]  halt_stat_o;
    logic [31:0] cyc_cnt_o;
    logic [31:0] lu_cnt_o;
    logic [31:0] mp_cnt_o;
    logic [31:0] ret_cnt_o;

    modport master (
        output D_icode_i, E_icode_i, M_icode_i, E_dstM_i, d_srcA_i, d_srcB_i,
               e_Cnd_i, m_stat_i, W_stat_i,
        input  F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o,
               cpu_halt_o, halt_stat_o, cyc_cnt_o, lu_cnt_o, mp_cnt_o, ret_cnt_o
    );

    modport slave (
        input  D_icode_i, E_icode_i, M_icode_i, E_dstM_i, d_srcA_i, d_srcB_i,
               e_Cnd_i, m_stat_i, W_stat_i,
        output F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o,
               cpu_halt_o, halt_stat_o, cyc_cnt_o, lu_cnt_o, mp_cnt_o, ret_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline hazard controller: stall/bubble generation, halt state machine and
// saturating performance counters.
module pipe_hazard_ctrl (
    input  logic                clk_i,
    input  logic                rst_n_i,
    pipe_hazard_ctrl_if.slave   bus
);
    localparam int unsigned CNT_W = 32;

    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd2;
    localparam logic [2:0] SINS = 3'd3;
    localparam logic [2:0] SHLT = 3'd4;

    typedef enum logic {ST_RUN = 1'b0, ST_STOP = 1'b1} state_t;

    state_t             state;
    logic               cpu_halt;
    logic [2:0]         halt_stat;
    logic [CNT_W-1:0]   cyc_cnt;
    logic [CNT_W-1:0]   lu_cnt;
    logic [CNT_W-1:0]   mp_cnt;
    logic [CNT_W-1:0]   ret_cnt;

    logic load_use;
    logic ret_pend;
    logic mispredict;
    logic exc_m;
    logic exc_w;
    logic ret_only;

    logic f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall;

    // Hazard detection from the current pipeline-register contents
    always_comb begin
        load_use   = ((bus.E_icode_i == IMRMOVQ) || (bus.E_icode_i == IPOPQ)) &&
                     (bus.E_dstM_i != RNONE) &&
                     ((bus.E_dstM_i == bus.d_srcA_i) || (bus.E_dstM_i == bus.d_srcB_i));
        ret_pend   = (bus.D_icode_i == IRET) || (bus.E_icode_i == IRET) ||
                     (bus.M_icode_i == IRET);
        mispredict = (bus.E_icode_i == IJXX) && !bus.e_Cnd_i;
        exc_m      = (bus.m_stat_i == SADR) || (bus.m_stat_i == SINS) || (bus.m_stat_i == SHLT);
        exc_w      = (bus.W_stat_i == SADR) || (bus.W_stat_i == SINS) || (bus.W_stat_i == SHLT);
        ret_only   = ret_pend && !load_use;
    end

    // Controls are combinational so the pipeline registers act on the same edge;
    // load_use wins stage D over a pending ret.
    always_comb begin
        f_stall  = 1'b0;
        d_stall  = 1'b0;
        d_bubble = 1'b0;
        e_bubble = 1'b0;
        m_bubble = 1'b0;
        w_stall  = 1'b0;
        if (state == ST_STOP) begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_bubble = 1'b1;
            m_bubble = 1'b1;
            w_stall  = 1'b1;
        end else begin
            f_stall  = load_use | ret_pend;
            d_stall  = load_use;
            d_bubble = mispredict | ret_only;
            e_bubble = mispredict | load_use;
            m_bubble = exc_m | exc_w;
            w_stall  = exc_w;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    // Run/stop state, halt capture and counters; everything freezes once stopped
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= ST_RUN;
            cpu_halt  <= 1'b0;
            halt_stat <= SAOK;
            cyc_cnt   <= '0;
            lu_cnt    <= '0;
            mp_cnt    <= '0;
            ret_cnt   <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    cyc_cnt <= sat_inc(cyc_cnt, 1'b1);
                    lu_cnt  <= sat_inc(lu_cnt, load_use);
                    mp_cnt  <= sat_inc(mp_cnt, mispredict);
                    ret_cnt <= sat_inc(ret_cnt, ret_only);
                    if (exc_w) begin
                        state     <= ST_STOP;
                        cpu_halt  <= 1'b1;
                        halt_stat <= bus.W_stat_i;
                    end
                end
                ST_STOP: begin
                    state    <= ST_STOP;
                    cpu_halt <= 1'b1;
                end
                default: begin
                    state    <= ST_RUN;
                    cpu_halt <= 1'b0;
                end
            endcase
        end
    end

    assign bus.F_stall_o   = f_stall;
    assign bus.D_stall_o   = d_stall;
    assign bus.D_bubble_o  = d_bubble;
    assign bus.E_bubble_o  = e_bubble;
    assign bus.M_bubble_o  = m_bubble;
    assign bus.W_stall_o   = w_stall;
    assign bus.cpu_halt_o  = cpu_halt;
    assign bus.halt_stat_o = halt_stat;
    assign bus.cyc_cnt_o   = cyc_cnt;
    assign bus.lu_cnt_o    = lu_cnt;
    assign bus.mp_cnt_o    = mp_cnt;
    assign bus.ret_cnt_o   = ret_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expectations, a negedge monitor checks them.
module tb_pipe_hazard_ctrl;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd2;
    localparam logic [2:0] SINS = 3'd3;
    localparam logic [2:0] SHLT = 3'd4;

    typedef struct packed {
        logic [3:0] d, e, m, dstm, sa, sb;
        logic       cnd;
        logic [2:0] ms, ws;
    } vec_t;

    typedef struct {
        string       name;
        logic [5:0]  ctrl;
        logic        halt;
        logic [2:0]  hstat;
        logic [31:0] cyc, lu, mp, ret;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t mon_e;

    logic        m_halt;
    logic [2:0]  m_hstat;
    logic [31:0] m_cyc, m_lu, m_mp, m_ret;

    pipe_hazard_ctrl_if bus ();
    pipe_hazard_ctrl dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", n, f, act, req);
        end
    endtask

    // Monitor: outputs are stable at the falling edge; compare every pending expectation
    always @(negedge clk) begin
        while (q.size() > 0) begin
            mon_e = q.pop_front();
            chk(mon_e.name, "ctrl", 32'({bus.F_stall_o, bus.D_stall_o, bus.D_bubble_o,
                                         bus.E_bubble_o, bus.M_bubble_o, bus.W_stall_o}),
                32'(mon_e.ctrl));
            chk(mon_e.name, "halt",  32'(bus.cpu_halt_o),  32'(mon_e.halt));
            chk(mon_e.name, "hstat", 32'(bus.halt_stat_o), 32'(mon_e.hstat));
            chk(mon_e.name, "cyc",   bus.cyc_cnt_o, mon_e.cyc);
            chk(mon_e.name, "lu",    bus.lu_cnt_o,  mon_e.lu);
            chk(mon_e.name, "mp",    bus.mp_cnt_o,  mon_e.mp);
            chk(mon_e.name, "ret",   bus.ret_cnt_o, mon_e.ret);
        end
    end

    function automatic logic [31:0] sat(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    function automatic vec_t vv(input logic [3:0] d, e, m, dstm, sa, sb,
                                input logic cnd, input logic [2:0] ms, ws);
        vec_t v;
        v.d = d; v.e = e; v.m = m; v.dstm = dstm; v.sa = sa; v.sb = sb;
        v.cnd = cnd; v.ms = ms; v.ws = ws;
        return v;
    endfunction

    task automatic model_reset();
        m_halt = 1'b0; m_hstat = SAOK;
        m_cyc = '0; m_lu = '0; m_mp = '0; m_ret = '0;
    endtask

    // Drive one cycle: ctrl = {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall}, inc = {lu,mp,ret}
    task automatic step(input string n, input vec_t v, input logic [5:0] c, input logic [2:0] inc);
        exp_t e;
        bus.D_icode_i = v.d;  bus.E_icode_i = v.e;  bus.M_icode_i = v.m;
        bus.E_dstM_i  = v.dstm; bus.d_srcA_i = v.sa; bus.d_srcB_i = v.sb;
        bus.e_Cnd_i   = v.cnd;  bus.m_stat_i = v.ms; bus.W_stat_i = v.ws;
        e.name = n; e.ctrl = c; e.halt = m_halt; e.hstat = m_hstat;
        e.cyc = m_cyc; e.lu = m_lu; e.mp = m_mp; e.ret = m_ret;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (rst_n && !m_halt) begin
            m_cyc = sat(m_cyc, 1'b1);
            m_lu  = sat(m_lu,  inc[2]);
            m_mp  = sat(m_mp,  inc[1]);
            m_ret = sat(m_ret, inc[0]);
            if (v.ws == SADR || v.ws == SINS || v.ws == SHLT) begin
                m_halt = 1'b1;
                m_hstat = v.ws;
            end
        end
    endtask

    vec_t idle;

    initial begin
        idle = vv(INOP, INOP, INOP, RNONE, RNONE, RNONE, 1'b1, SAOK, SAOK);
        model_reset();
        #1;
        step("reset", idle, 6'b000000, 3'b000);
        rst_n = 1'b1;
        step("idle", idle, 6'b000000, 3'b000);
        step("lu_srca", vv(INOP, IMRMOVQ, INOP, 4'h3, 4'h3, RNONE, 1'b1, SAOK, SAOK), 6'b110100, 3'b100);
        step("lu_ret",  vv(IRET, IMRMOVQ, INOP, 4'h3, 4'h3, RNONE, 1'b1, SAOK, SAOK), 6'b110100, 3'b100);
        step("lu_popq", vv(INOP, IPOPQ, INOP, 4'h4, RNONE, 4'h4, 1'b1, SAOK, SAOK),   6'b110100, 3'b100);
        step("lu_rnone", vv(INOP, IMRMOVQ, INOP, RNONE, RNONE, 4'h2, 1'b1, SAOK, SAOK), 6'b000000, 3'b000);
        step("ret_m",   vv(INOP, INOP, IRET, RNONE, RNONE, RNONE, 1'b1, SAOK, SAOK),  6'b101000, 3'b001);
        step("mispred", vv(INOP, IJXX, INOP, RNONE, RNONE, RNONE, 1'b0, SAOK, SAOK),  6'b001100, 3'b010);
        step("jxx_taken", vv(INOP, IJXX, INOP, RNONE, RNONE, RNONE, 1'b1, SAOK, SAOK), 6'b000000, 3'b000);
        step("mp_ret",  vv(IRET, IJXX, INOP, RNONE, RNONE, RNONE, 1'b0, SAOK, SAOK),  6'b101100, 3'b011);
        step("mem_adr", vv(INOP, INOP, INOP, RNONE, RNONE, RNONE, 1'b1, SADR, SAOK),  6'b000010, 3'b000);
        step("mem_ins", vv(INOP, INOP, INOP, RNONE, RNONE, RNONE, 1'b1, SINS, SAOK),  6'b000010, 3'b000);

        force dut.lu_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.lu_cnt;
        m_lu = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            step("lu_sat", vv(INOP, IMRMOVQ, INOP, 4'h3, 4'h3, RNONE, 1'b1, SAOK, SAOK), 6'b110100, 3'b100);
        end

        step("halt_edge", vv(INOP, INOP, INOP, RNONE, RNONE, RNONE, 1'b1, SAOK, SHLT), 6'b000011, 3'b000);
        step("stop_lu", vv(IRET, IMRMOVQ, INOP, 4'h3, 4'h3, RNONE, 1'b1, SAOK, SAOK), 6'b110111, 3'b100);
        step("stop_mp", vv(INOP, IJXX, INOP, RNONE, RNONE, RNONE, 1'b0, SAOK, SAOK),  6'b110111, 3'b010);

        #1;
        rst_n = 1'b0;
        model_reset();
        step("async_rst", idle, 6'b000000, 3'b000);
        rst_n = 1'b1;
        step("after_rst0", idle, 6'b000000, 3'b000);
        step("after_rst1", vv(INOP, IJXX, INOP, RNONE, RNONE, RNONE, 1'b0, SAOK, SAOK), 6'b001100, 3'b010);
        step("after_rst2", idle, 6'b000000, 3'b000);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0", q.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The module SHALL have one clock and one reset, with reset asynchronous and active-low.
REQ-002 clk_i  input  1  rising-edge clock shared with all pipeline registers.
REQ-003 rst_n_i  input  1  asynchronous active-low reset.
REQ-004 D_icode_i, E_icode_i, M_icode_i  input  4 each  icode held in the D, E and M pipeline registers.
REQ-005 E_dstM_i  input  4  E-stage memory destination register.
REQ-006 d_srcA_i, d_srcB_i  input  4 each  decode-stage source registers.
REQ-007 e_Cnd_i  input  1  execute-stage condition result.
REQ-008 m_stat_i, W_stat_i  input  3 each  memory-stage and writeback status codes (`SAOK/`SHLT/`SADR/`SINS).
REQ-009 F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o  output  1 each  pipeline-register controls.
REQ-010 cpu_halt_o  output  1  processor stopped.
REQ-011 halt_stat_o  output  3  status code that stopped the processor.
REQ-012 cyc_cnt_o, lu_cnt_o, mp_cnt_o, ret_cnt_o  output  32 each  cycle, load/use, mispredict and ret-stall counters.

Function
REQ-013 The control outputs SHALL be combinational from the current inputs and state, so the pipeline registers act on the same clock edge.
REQ-014 load_use condition: E_icode_i in {`IMRMOVQ,`IPOPQ}, E_dstM_i != `RNONE, and E_dstM_i equals d_srcA_i or d_srcB_i.
REQ-015 ret_pend condition: `IRET is present in any of D_icode_i, E_icode_i, M_icode_i.
REQ-016 mispredict condition: E_icode_i == `IJXX and e_Cnd_i == 0.
REQ-017 exc_m condition: m_stat_i is one of {`SADR,`SINS,`SHLT}.
REQ-018 exc_w condition: W_stat_i is one of {`SADR,`SINS,`SHLT}.
REQ-019 In state RUN, the outputs SHALL be:
- F_stall_o = load_use | ret_pend
- D_stall_o = load_use
- D_bubble_o = mispredict | (ret_pend & ~load_use)
- E_bubble_o = mispredict | load_use
- M_bubble_o = exc_m | exc_w
- W_stall_o = exc_w
REQ-020 D_stall_o and D_bubble_o SHALL never be 1 in the same cycle; load_use takes priority over ret_pend for stage D.
REQ-021 State machine: states RUN and STOP; reset enters RUN.
REQ-022 RUN->STOP on the rising edge where exc_w == 1; halt_stat_o captures W_stat_i on that edge.
REQ-023 STOP is terminal until reset.
REQ-024 In STOP, the outputs SHALL be F_stall_o = D_stall_o = W_stall_o = 1, E_bubble_o = M_bubble_o = 1 and D_bubble_o = 0, regardless of the other inputs.
REQ-025 cpu_halt_o SHALL be 1 only in STOP (registered, valid from the cycle after the transition).
REQ-026 cyc_cnt_o SHALL increment once per cycle in RUN and hold in STOP.
REQ-027 In RUN, lu_cnt_o SHALL increment on each load_use cycle, mp_cnt_o on each mispredict cycle, and ret_cnt_o on each cycle with ret_pend & ~load_use.
REQ-028 Counters SHALL saturate at 32'hFFFF_FFFF with no wrap.
REQ-029 When several conditions are true in the same cycle, each applicable counter SHALL increment independently.
REQ-030 On the transition cycle (exc_w first seen), the RUN equations SHALL apply and counters SHALL still update; all counters SHALL freeze from STOP onward.

Reset
REQ-031 While rst_n_i == 0, the module SHALL be in state RUN.
REQ-032 While rst_n_i == 0, cpu_halt_o SHALL be 0 and halt_stat_o SHALL be `SAOK.
REQ-033 While rst_n_i == 0, all counters SHALL be 0.
REQ-034 Reset assertion mid-operation, including in STOP, SHALL clear all state immediately without waiting for a clock edge.
REQ-035 On the first rising edge after release, the module SHALL behave as RUN.
REQ-036 During reset, the combinational control outputs SHALL follow the RUN equations, and the counters SHALL not count.

Verification
REQ-037 Load/use: E_icode_i=`IMRMOVQ, E_dstM_i=4'h3, d_srcA_i=4'h3 -> F_stall_o=1, D_stall_o=1, E_bubble_o=1, D_bubble_o=0; lu_cnt_o 0->1 after the edge.
REQ-038 Load/use plus ret: same stimulus with D_icode_i=`IRET -> D_stall_o=1, D_bubble_o=0, F_stall_o=1; ret_cnt_o unchanged.
REQ-039 Mispredict: E_icode_i=`IJXX, e_Cnd_i=0 -> D_bubble_o=1, E_bubble_o=1, F_stall_o=0; mp_cnt_o increments. With e_Cnd_i=1, all controls=0.
REQ-040 Halt: W_stat_i=`SHLT for one cycle, then `SAOK ->
- during that cycle: M_bubble_o=1, W_stall_o=1
- next cycle: cpu_halt_o=1, halt_stat_o=`SHLT, outputs per REQ-024, cyc_cnt_o frozen
REQ-041 Memory exception: m_stat_i=`SADR with W_stat_i=`SAOK -> M_bubble_o=1, W_stall_o=0, state stays RUN.
REQ-042 Saturation and reset: preload via long run or force lu_cnt_o=32'hFFFF_FFFE, apply 3 load_use cycles -> lu_cnt_o ends at 32'hFFFF_FFFF; assert rst_n_i=0 asynchronously in STOP -> all counters 0, cpu_halt_o=0 immediately.
